// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit responder: register offsets,
// STATUS bit positions and the bit-level transmitter state encoding.
package uart_pkg;

    typedef enum logic [1:0] {
        TXDATA  = 2'd0,
        STATUS  = 2'd1,
        BAUDDIV = 2'd2,
        CTRL    = 2'd3
    } reg_addr_e;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // The STATUS count field is 4 bits and sticks at 15 for deeper FIFOs.
    function automatic logic [3:0] sat_nibble(input int unsigned c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/uart_tx_responder_if.sv
// Data-memory bus slice seen by the UART responder. The core side drives
// select, address, store data, strobes and load request; the responder returns load data.
interface uart_tx_responder_if;
    logic        sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_sdata;
    logic [3:0]  mem_mask;
    logic        mem_lenable;
    logic [31:0] mem_ldata;

    modport master (
        output sel, mem_addr, mem_sdata, mem_mask, mem_lenable,
        input  mem_ldata
    );

    modport slave (
        input  sel, mem_addr, mem_sdata, mem_mask, mem_lenable,
        output mem_ldata
    );
endinterface

// File: rtl/uart_tx_responder_fifo.sv
// Pointer-based synchronous FIFO (module sync_fifo). Pushes when full and
// pops when empty are ignored; the head entry is visible on o_data.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (o_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/uart_tx_responder.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus.
// Optional UART_TX_IRQ_EN adds CTRL[0] interrupt enable and the irq_tx_done output.
import uart_pkg::*;

module uart_tx_responder #(
    parameter int DEPTH    = 8,
    parameter int BAUD_RST = 433
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_responder_if.slave  bus,
    output logic                uart_tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic                irq_tx_done
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    reg_addr_e   w_addr;
    logic        w_write;
    logic        w_push_req;
    logic        w_ovf_clr;
    logic        w_pop;
    logic [7:0]  w_fifo_data;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic        w_ctrl_bit0;
    logic        w_unused;

    logic        r_overflow;
    logic [15:0] r_baud;

    tx_state_e   r_state,   w_state_nx;
    logic [15:0] r_timer,   w_timer_nx;
    logic [2:0]  r_bit_idx, w_bit_idx_nx;
    logic [7:0]  r_shift,   w_shift_nx;
    logic        r_tx,      w_tx_nx;

    assign w_addr     = reg_addr_e'(bus.mem_addr[3:2]);
    assign w_write    = bus.sel && (bus.mem_mask != 4'b0000);
    assign w_push_req = w_write && (w_addr == TXDATA) && bus.mem_mask[0];
    assign w_ovf_clr  = w_write && (w_addr == STATUS) && bus.mem_mask[0] && bus.mem_sdata[STAT_OVF];
    assign w_unused   = ^{bus.mem_addr[31:4], bus.mem_addr[1:0], bus.mem_sdata[31:16]};

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_req),
        .i_data  (bus.mem_sdata[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // A push into a full FIFO is lost even when the transmitter pops that same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_push_req && w_fifo_full) begin
            r_overflow <= 1'b1;
        end else if (w_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_baud <= 16'(BAUD_RST);
        end else if (w_write && (w_addr == BAUDDIV)) begin
            if (bus.mem_mask[0]) r_baud[7:0]  <= bus.mem_sdata[7:0];
            if (bus.mem_mask[1]) r_baud[15:8] <= bus.mem_sdata[15:8];
        end
    end

`ifdef UART_TX_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_write && (w_addr == CTRL) && bus.mem_mask[0]) begin
                r_irq_en <= bus.mem_sdata[0];
            end
            r_irq <= r_irq_en && w_fifo_empty && (r_state == IDLE);
        end
    end

    assign w_ctrl_bit0 = r_irq_en;
    assign irq_tx_done = r_irq;
`else
    assign w_ctrl_bit0 = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_timer   <= w_timer_nx;
            r_bit_idx <= w_bit_idx_nx;
            r_shift   <= w_shift_nx;
            r_tx      <= w_tx_nx;
        end
    end

    // Each bit lasts r_baud+1 clocks: the timer is loaded at bit start and the bit ends at zero.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_state_nx   = r_state;
        w_timer_nx   = (r_timer != 16'd0) ? r_timer - 16'd1 : r_timer;
        w_bit_idx_nx = r_bit_idx;
        w_shift_nx   = r_shift;
        w_tx_nx      = r_tx;
        w_pop        = 1'b0;

        case (r_state)
            IDLE: begin
                w_tx_nx = 1'b1;
                if (!w_fifo_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = w_fifo_data;
                    w_timer_nx = r_baud;
                    w_tx_nx    = 1'b0;
                    w_state_nx = START;
                end
            end
            START: begin
                if (r_timer == 16'd0) begin
                    w_timer_nx   = r_baud;
                    w_bit_idx_nx = 3'd0;
                    w_tx_nx      = r_shift[0];
                    w_state_nx   = DATA;
                end
            end
            DATA: begin
                if (r_timer == 16'd0) begin
                    w_timer_nx = r_baud;
                    if (r_bit_idx == 3'd7) begin
                        w_tx_nx    = 1'b1;
                        w_state_nx = STOP;
                    end else begin
                        w_bit_idx_nx = r_bit_idx + 3'd1;
                        w_shift_nx   = {1'b0, r_shift[7:1]};
                        w_tx_nx      = r_shift[1];
                    end
                end
            end
            STOP: begin
                if (r_timer == 16'd0) begin
                    if (!w_fifo_empty) begin
                        w_pop      = 1'b1;
                        w_shift_nx = w_fifo_data;
                        w_timer_nx = r_baud;
                        w_tx_nx    = 1'b0;
                        w_state_nx = START;
                    end else begin
                        w_tx_nx    = 1'b1;
                        w_state_nx = IDLE;
                    end
                end
            end
            default: begin
                w_tx_nx    = 1'b1;
                w_state_nx = IDLE;
            end
        endcase
    end

    assign uart_tx = r_tx;

    always_comb begin
        w_status                 = '0;
        w_status[STAT_BUSY]      = (r_state != IDLE);
        w_status[STAT_FULL]      = w_fifo_full;
        w_status[STAT_EMPTY]     = w_fifo_empty;
        w_status[STAT_OVF]       = r_overflow;
        w_status[7:4]            = sat_nibble(32'(w_fifo_count));
    end

    always_comb begin
        w_rdata = '0;
        if (bus.sel && bus.mem_lenable) begin
            case (w_addr)
                STATUS:  w_rdata = w_status;
                BAUDDIV: w_rdata = {16'h0000, r_baud};
                CTRL:    w_rdata = {31'h0, w_ctrl_bit0};
                default: w_rdata = '0;
            endcase
        end
    end

    assign bus.mem_ldata = w_rdata;

endmodule

// File: tb/tb_uart_tx_responder.sv
// Directed bench for uart_tx_responder: register access, 8N1 framing,
// back-to-back frames, FIFO overflow, asynchronous reset and optional IRQ.
`timescale 1ns/1ps
import uart_pkg::*;

module tb_uart_tx_responder;

    logic clk;
    logic rst;
    logic uart_tx;
`ifdef UART_TX_IRQ_EN
    logic irq_tx_done;
`endif

    int n_vec;
    int n_err;

    uart_tx_responder_if bus ();

    uart_tx_responder #(.DEPTH(8), .BAUD_RST(433)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .uart_tx     (uart_tx)
`ifdef UART_TX_IRQ_EN
        ,
        .irq_tx_done (irq_tx_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One store: driven at the falling edge, taken at the following rising edge.
    task automatic bus_write(input logic s, input reg_addr_e a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        bus.sel       = s;
        bus.mem_addr  = {28'h0, a, 2'b00};
        bus.mem_sdata = d;
        bus.mem_mask  = m;
        @(posedge clk);
        #1;
        bus.sel      = 1'b0;
        bus.mem_mask = 4'h0;
    endtask

    task automatic bus_read(input reg_addr_e a, output logic [31:0] d);
        bus.sel         = 1'b1;
        bus.mem_addr    = {28'h0, a, 2'b00};
        bus.mem_lenable = 1'b1;
        #1;
        d = bus.mem_ldata;
        bus.sel         = 1'b0;
        bus.mem_lenable = 1'b0;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[k];
    endfunction

    initial begin
        logic [31:0] rd;
        logic [9:0]  exp55;
        logic [7:0]  b;

        n_vec = 0;
        n_err = 0;
        rst             = 1'b0;
        bus.sel         = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_sdata   = '0;
        bus.mem_mask    = 4'h0;
        bus.mem_lenable = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_tx", 32'(uart_tx), 32'h1);
        check("rst_ldata_idle", bus.mem_ldata, 32'h0);
        bus_read(STATUS, rd);  check("rst_status", rd, 32'h4);
        bus_read(BAUDDIV, rd); check("rst_bauddiv", rd, 32'd433);
        bus_read(CTRL, rd);    check("rst_ctrl", rd, 32'h0);

        // Byte strobes, deselected writes, TXDATA without strobe 0
        bus_write(1'b1, BAUDDIV, 32'h0000_ABCD, 4'b0010);
        bus_read(BAUDDIV, rd); check("baud_hi_strobe", rd, 32'h0000_ABB1);
        bus_write(1'b0, BAUDDIV, 32'h0000_1234, 4'b0011);
        bus_read(BAUDDIV, rd); check("baud_sel_low", rd, 32'h0000_ABB1);
        bus_write(1'b1, TXDATA, 32'h0000_5A00, 4'b0010);
        bus_read(STATUS, rd);  check("tx_no_strobe0", rd, 32'h4);
        bus_read(TXDATA, rd);  check("txdata_reads0", rd, 32'h0);
        bus.sel = 1'b1; bus.mem_addr = 32'h4; #1;
        check("ldata_no_lenable", bus.mem_ldata, 32'h0);
        bus.sel = 1'b0;

        // 0x55 at BAUDDIV=3: ten 4-clock bits
        exp55 = 10'b10_1010_1010;
        bus_write(1'b1, BAUDDIV, 32'd3, 4'b0011);
        bus_write(1'b1, TXDATA, 32'h55, 4'b0001);
        bus_read(STATUS, rd);  check("t0_status", rd, 32'h10);
        @(posedge clk); #1;
        bus_read(STATUS, rd);  check("t1_status", rd, 32'h05);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("f55_b%0d_first", k), 32'(uart_tx), 32'(exp55[k]));
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("f55_b%0d_last", k), 32'(uart_tx), 32'(exp55[k]));
            if (k == 9) begin
                bus_read(STATUS, rd); check("f55_busy_end", rd, 32'h05);
            end
            @(posedge clk);
            #1;
        end
        bus_read(STATUS, rd);  check("f55_idle", rd, 32'h4);

        // BAUDDIV=0, 0xA1 then 0x3C back to back
        bus_write(1'b1, BAUDDIV, 32'd0, 4'b0011);
        bus_write(1'b1, TXDATA, 32'hA1, 4'b0001);
        bus_write(1'b1, TXDATA, 32'h3C, 4'b0001);
        for (int k = 0; k < 20; k++) begin
            b = (k < 10) ? 8'hA1 : 8'h3C;
            check($sformatf("b2b_bit%0d", k), 32'(uart_tx), 32'(frame_bit(b, k % 10)));
            @(posedge clk);
            #1;
        end
        bus_read(STATUS, rd);  check("b2b_idle", rd, 32'h4);

        // Overflow: 10 rapid writes at BAUDDIV=100
        bus_write(1'b1, BAUDDIV, 32'd100, 4'b0011);
        for (int i = 0; i < 10; i++) begin
            bus_write(1'b1, TXDATA, 32'h00, 4'b0001);
        end
        bus_read(STATUS, rd);  check("ovf_status", rd, 32'h8B);
        bus_write(1'b1, STATUS, 32'h8, 4'b0001);
        bus_read(STATUS, rd);  check("ovf_cleared", rd, 32'h83);

        // Reset mid-frame, about clock 15 of the start bit
        repeat (5) @(posedge clk);
        #2;
        check("pre_rst_tx", 32'(uart_tx), 32'h0);
        rst = 1'b0;
        #1;
        check("async_rst_tx", 32'(uart_tx), 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        bus_read(STATUS, rd);  check("post_rst_status", rd, 32'h4);
        bus_read(BAUDDIV, rd); check("post_rst_baud", rd, 32'd433);
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_tx", 32'(uart_tx), 32'h1);

`ifdef UART_TX_IRQ_EN
        // Interrupt on transmit completion
        bus_write(1'b1, BAUDDIV, 32'd1, 4'b0011);
        bus_write(1'b1, CTRL, 32'h1, 4'b0001);
        bus_read(CTRL, rd);    check("ctrl_rd", rd, 32'h1);
        @(posedge clk); #1;
        check("irq_idle", 32'(irq_tx_done), 32'h1);
        bus_write(1'b1, TXDATA, 32'hC3, 4'b0001);
        @(posedge clk); #1;
        check("irq_frame_start", 32'(irq_tx_done), 32'h0);
        repeat (19) @(posedge clk);
        #1;
        check("irq_frame_mid", 32'(irq_tx_done), 32'h0);
        @(posedge clk); #1;
        bus_read(STATUS, rd);  check("irq_fsm_idle", rd, 32'h4);
        check("irq_delay", 32'(irq_tx_done), 32'h0);
        @(posedge clk); #1;
        check("irq_done", 32'(irq_tx_done), 32'h1);
        bus_write(1'b1, CTRL, 32'h0, 4'b0001);
        check("irq_hold", 32'(irq_tx_done), 32'h1);
        @(posedge clk); #1;
        check("irq_cleared", 32'(irq_tx_done), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_responder.md
# uart_tx_responder

Memory-mapped UART transmitter that answers the RV32I core's data-memory bus as a responder in the UART address region. Software writes bytes into a transmit FIFO and polls status. A bit-level state machine serialises the bytes as 8N1 frames on `uart_tx`. The block sits beside the data memory, with its select driven by the device-select decoder.

## Interface
- `DEPTH`, 8: transmit FIFO entries; power of two, ≥2.
- `BAUD_RST`, 433: reset value of BAUDDIV; bit period is BAUDDIV+1 clocks.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low; all state clears immediately when low.
- `sel`  in  1  region select from the device-select decoder.
- `mem_addr`  in  32  byte address; only [3:2] are decoded.
- `mem_sdata`  in  32  store data.
- `mem_mask`  in  4  byte write strobes, already qualified by store enable; nonzero means write.
- `mem_lenable`  in  1  load request.
- `mem_ldata`  out  32  load data, combinational.
- `uart_tx`  out  1  serial line, idle high.

## Operation
- Register map, selected by `mem_addr[3:2]`:
  - 0 TXDATA: write with `mem_mask[0]` pushes `mem_sdata[7:0]`. Reads as 0.
  - 1 STATUS, read: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), [7:4] count (saturating at 15), others 0. Writing 1 to bit3 with `mem_mask[0]` clears overflow.
  - 2 BAUDDIV: [15:0] read/write, byte strobes honoured.
  - 3 CTRL: see Configuration.
- Writes take effect only when `sel` is high and `mem_mask` is nonzero. Each clock with a nonzero mask is one write.
- Push when full: byte dropped, overflow set, FIFO unchanged. This holds even if a pop occurs in the same cycle.
- Push and pop in the same cycle when not full: both occur and count is unchanged.
- FSM states and transitions:
  - IDLE: leaves only when FIFO is non-empty; pops the head into the shift register, goes to START.
  - START: line 0 for one bit period, then DATA.
  - DATA: 8 bits, LSB first, one period each, via a 3-bit index.
  - STOP: line 1 for one period. Then, if FIFO is non-empty, pop and go directly to START with no idle gap; else go to IDLE.
- Bit timer: down-counter loaded with BAUDDIV at every bit start. A bit ends when the counter reaches 0.
  - A BAUDDIV write mid-frame affects only bits that start afterwards.
  - BAUDDIV=0 gives 1 clock per bit.
- `mem_ldata`: the selected register when `sel && mem_lenable`, otherwise 32'h0. Reads have no side effects.

## Timing
- Reset values:
  - `uart_tx`=1, FSM IDLE, FIFO empty, overflow 0, BAUDDIV=`BAUD_RST`, CTRL 0.
  - `mem_ldata`=0, because `mem_lenable` is low.
- Write latency:
  - A byte pushed at edge t into an empty FIFO with the FSM IDLE is popped at edge t+1.
  - `uart_tx` falls after edge t+1.
  - STATUS shows empty=0 in the cycle after t, and busy=1 after t+1.
- Frame length is 10×(BAUDDIV+1) clocks. Back-to-back frames have no gap.
- Load data is valid in the same cycle as `mem_lenable`, with zero wait states. This matches the core's load sampling on the following edge.
- Reset asserted mid-frame: `uart_tx` returns high asynchronously and the FIFO contents are discarded.

## Configuration
- Macro: `UART_TX_IRQ_EN`.
- Defined:
  - Adds output `irq_tx_done` (1 bit).
  - CTRL bit0 is the interrupt enable, read/write.
  - `irq_tx_done` = CTRL[0] & FIFO empty & FSM IDLE, registered, with 1-cycle delay from the condition.
- Undefined:
  - No `irq_tx_done` port.
  - CTRL reads 0 and writes are ignored.

## Structure
- Package `uart_pkg`:
  - Register offsets (TXDATA/STATUS/BAUDDIV/CTRL).
  - STATUS bit indices.
  - FSM state encoding IDLE/START/DATA/STOP.
- Sub-module `sync_fifo`:
  - Parameterised width/depth, pointer-based.
  - Outputs `full`/`empty`/`count`.
  - Synchronous push/pop, same `clk`/`rst`.

## Test plan
- Reset, then read STATUS: 0x00000004. `uart_tx`=1. BAUDDIV reads 433.
- BAUDDIV=3, write 0x55 to TXDATA → `uart_tx` sequence (4 clocks each) 0,1,0,1,0,1,0,1,0,1. Total 40 clocks, then busy=0.
- BAUDDIV=0, write 0xA1 then 0x3C on consecutive cycles → 20 consecutive bit periods, with no idle high between STOP and the second START.
- DEPTH=8, BAUDDIV=100, 10 rapid writes: first is popped, 8 fill the FIFO, 10th dropped → STATUS full=1, overflow=1. Writing 0x8 to STATUS clears overflow only.
- Reset pulled low at clock 15 of a frame → `uart_tx`=1 without waiting for an edge. STATUS reads 0x4 after release.
- With `UART_TX_IRQ_EN`: CTRL=1, send one byte at BAUDDIV=1 → `irq_tx_done` low during the frame, high one cycle after return to IDLE. Clearing CTRL drops it.
